// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory responder: access sizes and FSM states.
package dmem_pkg;

  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_BYTE = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StWait = 2'b01,
    StAck  = 2'b10
  } dmem_state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for the data memory: write mask, write-data replication,
// read extract with zero-extension and misalignment/reserved-size detect.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        misalign_o
);

  logic [31:0] rshift;

  always_comb begin
    be_o       = 4'b0000;
    wdata_o    = 32'h0;
    rdata_o    = 32'h0;
    misalign_o = 1'b0;
    rshift     = rword_i >> {addr_lo_i, 3'b000};
    unique case (size_i)
      SIZE_WORD: begin
        misalign_o = (addr_lo_i != 2'b00);
        be_o       = 4'b1111;
        wdata_o    = wdata_i;
        rdata_o    = rword_i;
      end
      SIZE_HALF: begin
        misalign_o = addr_lo_i[0];
        be_o       = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o    = {2{wdata_i[15:0]}};
        rdata_o    = {16'h0, rshift[15:0]};
      end
      SIZE_BYTE: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {24'h0, rshift[7:0]};
      end
      default: misalign_o = 1'b1;
    endcase
    // A rejected access neither writes nor returns data.
    if (misalign_o) begin
      be_o    = 4'b0000;
      rdata_o = 32'h0;
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Wait-state data-memory responder: inserts WAIT_CYCLES not-ready cycles, then
// completes a byte/half/word access against a word-organised array.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned DEPTH_WORDS = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mreq,
  input  logic        write,
  input  logic [1:0]  size,
  input  logic [31:0] dad,
  input  logic [31:0] ddt_wr,
  output logic [31:0] ddt_rd,
  output logic        ddt_oe,
  output logic        ackd_n,
  output logic        err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CntLoad = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  dmem_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] dad_q, dad_d;
  logic [1:0]  size_q, size_d;
  logic        write_q, write_d;
  logic [31:0] wdata_q, wdata_d;

  logic        busy, complete;
  logic [31:0] eff_dad, eff_wdata;
  logic [1:0]  eff_size;
  logic        eff_write;

  logic [31:0] mem [DEPTH_WORDS];
  logic [AW-1:0] idx;
  logic [31:0] rword, rdata, wdata_sh;
  logic [3:0]  be;
  logic        misalign, mem_we;
  logic        unused_dad;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dad_d    = dad_q;
    size_d   = size_q;
    write_d  = write_q;
    wdata_d  = wdata_q;
    busy     = 1'b0;
    complete = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (mreq) begin
          dad_d   = dad;
          size_d  = size;
          write_d = write;
          wdata_d = ddt_wr;
          if (WAIT_CYCLES == 0) begin
            complete = 1'b1;
          end else begin
            busy  = 1'b1;
            cnt_d = CntLoad;
            // The request cycle is itself the first not-ready cycle.
            state_d = (WAIT_CYCLES == 1) ? StAck : StWait;
          end
        end
      end
      StWait: begin
        busy = 1'b1;
        if (!mreq) begin
          state_d = StIdle;
          cnt_d   = 4'd0;
        end else if (cnt_q <= 4'd1) begin
          state_d = StAck;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StAck: begin
        complete = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (rst) begin
      state_d  = StIdle;
      cnt_d    = 4'd0;
      dad_d    = 32'h0;
      size_d   = 2'b00;
      write_d  = 1'b0;
      wdata_d  = 32'h0;
      busy     = 1'b0;
      complete = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
    cnt_q   <= cnt_d;
    dad_q   <= dad_d;
    size_q  <= size_d;
    write_q <= write_d;
    wdata_q <= wdata_d;
  end

  // Zero-wait accesses complete in the request cycle from the live inputs.
  always_comb begin
    if (state_q == StIdle) begin
      eff_dad   = dad;
      eff_size  = size;
      eff_write = write;
      eff_wdata = ddt_wr;
    end else begin
      eff_dad   = dad_q;
      eff_size  = size_q;
      eff_write = write_q;
      eff_wdata = wdata_q;
    end
  end

  assign idx        = eff_dad[AW+1:2];
  assign rword      = mem[idx];
  assign unused_dad = ^eff_dad[31:AW+2];

  dmem_lane_align u_lane_align (
    .size_i     (eff_size),
    .addr_lo_i  (eff_dad[1:0]),
    .wdata_i    (eff_wdata),
    .rword_i    (rword),
    .be_o       (be),
    .wdata_o    (wdata_sh),
    .rdata_o    (rdata),
    .misalign_o (misalign)
  );

  assign mem_we = complete & eff_write & ~misalign;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata_sh[8*i +: 8];
      end
    end
  end

  assign ackd_n = busy;
  assign err    = complete & misalign;
  assign ddt_oe = complete & ~eff_write;
  assign ddt_rd = ddt_oe ? rdata : 32'h0;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (2 and 0 wait states) checked every
// cycle against a byte-level transaction model, plus literal directed vectors.
module tb_dmem_responder;

  localparam int WA = 2;
  localparam int WB = 0;
  localparam int DA = 4096;
  localparam int DB = 256;

  logic        clk = 1'b0;
  logic        rst_v   [2];
  logic        mreq_v  [2];
  logic        write_v [2];
  logic [1:0]  size_v  [2];
  logic [31:0] dad_v   [2];
  logic [31:0] wdata_v [2];
  logic [31:0] rd_v    [2];
  logic        oe_v    [2];
  logic        ackd_v  [2];
  logic        err_v   [2];

  int n_pass = 0;
  int n_total = 0;

  int wp [2] = '{WA, WB};
  int dp [2] = '{DA, DB};

  // Model state: in-flight request and byte-addressed memory image.
  bit          act [2];
  int          el  [2];
  logic        lw  [2];
  logic [1:0]  ls  [2];
  logic [31:0] la  [2];
  logic [31:0] ld  [2];
  logic [7:0]  mm  [int unsigned];

  logic [31:0] last_rd;
  logic        last_oe, last_err;

  always #5 clk = ~clk;

  dmem_responder #(.WAIT_CYCLES(WA), .DEPTH_WORDS(DA)) dut_a (
    .clk(clk), .rst(rst_v[0]), .mreq(mreq_v[0]), .write(write_v[0]), .size(size_v[0]),
    .dad(dad_v[0]), .ddt_wr(wdata_v[0]), .ddt_rd(rd_v[0]), .ddt_oe(oe_v[0]),
    .ackd_n(ackd_v[0]), .err(err_v[0])
  );

  dmem_responder #(.WAIT_CYCLES(WB), .DEPTH_WORDS(DB)) dut_b (
    .clk(clk), .rst(rst_v[1]), .mreq(mreq_v[1]), .write(write_v[1]), .size(size_v[1]),
    .dad(dad_v[1]), .ddt_wr(wdata_v[1]), .ddt_rd(rd_v[1]), .ddt_oe(oe_v[1]),
    .ackd_n(ackd_v[1]), .err(err_v[1])
  );

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
  endtask

  function automatic bit bad_access(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b00 && a[1:0] != 2'b00);
  endfunction

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 4 : (sz == 2'b01) ? 2 : 1;
  endfunction

  function automatic int unsigned key(input int d, input logic [31:0] a, input int i);
    return d * 32'h0010_0000 + (a % (dp[d] * 4)) + i;
  endfunction

  function automatic void commit(input int d, input logic [1:0] sz, input logic [31:0] a,
                                 input logic [31:0] wd);
    if (bad_access(sz, a)) return;
    for (int i = 0; i < nbytes(sz); i++) mm[key(d, a, i)] = wd[8*i +: 8];
  endfunction

  function automatic logic [31:0] model_read(input int d, input logic [1:0] sz,
                                             input logic [31:0] a, output bit known);
    logic [31:0] v = 32'h0;
    known = 1'b1;
    for (int i = 0; i < nbytes(sz); i++) begin
      if (mm.exists(key(d, a, i))) v[8*i +: 8] = mm[key(d, a, i)];
      else known = 1'b0;
    end
    return v;
  endfunction

  // Model advance at the active edge, from the inputs the DUT also samples.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst_v[d]) begin
        act[d] = 1'b0;
      end else if (act[d]) begin
        if (el[d] < wp[d]) begin
          if (!mreq_v[d]) act[d] = 1'b0;
          else el[d]++;
        end else begin
          if (lw[d]) commit(d, ls[d], la[d], ld[d]);
          act[d] = 1'b0;
        end
      end else if (mreq_v[d]) begin
        if (wp[d] == 0) begin
          if (write_v[d]) commit(d, size_v[d], dad_v[d], wdata_v[d]);
        end else begin
          act[d] = 1'b1;
          el[d]  = 1;
          lw[d]  = write_v[d];
          ls[d]  = size_v[d];
          la[d]  = dad_v[d];
          ld[d]  = wdata_v[d];
        end
      end
    end
  end

  // Compare every cycle, mid-cycle.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic        e_ack, e_oe, e_err, cw;
      logic [1:0]  cs;
      logic [31:0] e_rd, ca;
      bit          comp, known;
      e_ack = 1'b0; e_oe = 1'b0; e_err = 1'b0; e_rd = 32'h0;
      comp = 1'b0; known = 1'b1; cw = 1'b0; cs = 2'b00; ca = 32'h0;
      if (!rst_v[d]) begin
        if (act[d]) begin
          if (el[d] < wp[d]) e_ack = 1'b1;
          else begin comp = 1'b1; cw = lw[d]; cs = ls[d]; ca = la[d]; end
        end else if (mreq_v[d]) begin
          if (wp[d] == 0) begin comp = 1'b1; cw = write_v[d]; cs = size_v[d]; ca = dad_v[d]; end
          else e_ack = 1'b1;
        end
      end
      if (comp) begin
        e_err = bad_access(cs, ca);
        e_oe  = !cw;
        if (!cw && !e_err) e_rd = model_read(d, cs, ca, known);
      end
      check($sformatf("ackd_n dut%0d", d), {31'h0, ackd_v[d]}, {31'h0, e_ack});
      check($sformatf("ddt_oe dut%0d", d), {31'h0, oe_v[d]}, {31'h0, e_oe});
      check($sformatf("err dut%0d", d), {31'h0, err_v[d]}, {31'h0, e_err});
      if (known) check($sformatf("ddt_rd dut%0d", d), rd_v[d], e_rd);
    end
  end

  task automatic txn(input int d, input logic wr, input logic [1:0] sz, input logic [31:0] a,
                     input logic [31:0] wd, output int nwait);
    nwait = 0;
    mreq_v[d] = 1'b1; write_v[d] = wr; size_v[d] = sz; dad_v[d] = a; wdata_v[d] = wd;
    forever begin
      @(negedge clk);
      if (ackd_v[d] == 1'b0) begin
        last_rd = rd_v[d]; last_oe = oe_v[d]; last_err = err_v[d];
        break;
      end
      nwait++;
      if (nwait > 40) begin
        n_total++;
        $display("FAIL ack_timeout dut%0d: got %0d not-ready cycles, required %0d", d, nwait,
                 wp[d]);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int d, input int n);
    mreq_v[d] = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic random_phase(input int d, input int count);
    int nw;
    logic wr;
    logic [1:0] sz;
    logic [31:0] a;
    for (int i = 0; i < 16; i++) txn(d, 1'b1, 2'b00, i * 4, $urandom, nw);
    for (int k = 0; k < count; k++) begin
      wr = 1'($urandom_range(0, 1));
      sz = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      a  = $urandom_range(0, 63) + dp[d] * 4 * $urandom_range(0, 3);
      txn(d, wr, sz, a, $urandom, nw);
      check($sformatf("rand_latency dut%0d", d), nw, wp[d]);
      if ($urandom_range(0, 2) != 0) idle(d, $urandom_range(1, 2));
    end
    idle(d, 1);
  endtask

  initial begin
    int nw;
    for (int d = 0; d < 2; d++) begin
      rst_v[d] = 1'b1; mreq_v[d] = 1'b0; write_v[d] = 1'b0;
      size_v[d] = 2'b00; dad_v[d] = 32'h0; wdata_v[d] = 32'h0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst_v[0] = 1'b0; rst_v[1] = 1'b0;

    // Two-wait-state instance: directed vectors.
    txn(0, 1'b1, 2'b00, 32'h100, 32'hDEADBEEF, nw);
    check("word_write_latency", nw, 2);
    txn(0, 1'b0, 2'b00, 32'h100, 32'h0, nw);
    check("word_read_data", last_rd, 32'hDEADBEEF);
    check("word_read_oe", {31'h0, last_oe}, 32'h1);
    idle(0, 1);
    txn(0, 1'b1, 2'b00, 32'h100, 32'h11223344, nw);
    txn(0, 1'b1, 2'b10, 32'h103, 32'h000000A5, nw);
    txn(0, 1'b0, 2'b00, 32'h100, 32'h0, nw);
    check("byte_merge_word", last_rd, 32'hA5223344);
    txn(0, 1'b0, 2'b10, 32'h103, 32'h0, nw);
    check("byte_read_ext", last_rd, 32'h000000A5);
    txn(0, 1'b1, 2'b00, 32'h200, 32'h0BADF00D, nw);
    txn(0, 1'b1, 2'b01, 32'h201, 32'h0000FFFF, nw);
    check("half_misalign_err", {31'h0, last_err}, 32'h1);
    txn(0, 1'b0, 2'b00, 32'h200, 32'h0, nw);
    check("misalign_no_write", last_rd, 32'h0BADF00D);
    txn(0, 1'b0, 2'b11, 32'h204, 32'h0, nw);
    check("rsvd_size_err", {31'h0, last_err}, 32'h1);
    check("rsvd_size_rd", last_rd, 32'h0);
    txn(0, 1'b1, 2'b00, 32'h300, 32'h01010101, nw);
    idle(0, 1);

    // Abort: mreq withdrawn while waiting.
    mreq_v[0] = 1'b1; write_v[0] = 1'b1; size_v[0] = 2'b00;
    dad_v[0] = 32'h300; wdata_v[0] = 32'hFFFFFFFF;
    @(posedge clk); #1;
    mreq_v[0] = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("abort_ackd_idle", {31'h0, ackd_v[0]}, 32'h0);
    @(posedge clk); #1;
    txn(0, 1'b0, 2'b00, 32'h300, 32'h0, nw);
    check("abort_no_write", last_rd, 32'h01010101);
    idle(0, 1);

    // Reset while waiting.
    mreq_v[0] = 1'b1; write_v[0] = 1'b1; size_v[0] = 2'b00;
    dad_v[0] = 32'h300; wdata_v[0] = 32'hFFFFFFFF;
    @(posedge clk); #1;
    rst_v[0] = 1'b1;
    @(posedge clk); #1;
    rst_v[0] = 1'b0; mreq_v[0] = 1'b0;
    @(negedge clk);
    check("reset_ackd", {31'h0, ackd_v[0]}, 32'h0);
    @(posedge clk); #1;
    txn(0, 1'b0, 2'b00, 32'h300, 32'h0, nw);
    check("reset_no_write", last_rd, 32'h01010101);

    txn(0, 1'b1, 2'b00, DA * 4, 32'hCAFEF00D, nw);
    txn(0, 1'b0, 2'b00, 32'h0, 32'h0, nw);
    check("wrap_around", last_rd, 32'hCAFEF00D);
    idle(0, 1);

    // Zero-wait instance: back-to-back halves.
    txn(1, 1'b1, 2'b01, 32'h200, 32'h00001234, nw);
    check("zw_half0_latency", nw, 0);
    txn(1, 1'b1, 2'b01, 32'h202, 32'h00005678, nw);
    check("zw_half1_latency", nw, 0);
    txn(1, 1'b0, 2'b00, 32'h200, 32'h0, nw);
    check("zw_half_merge", last_rd, 32'h56781234);
    idle(1, 1);

    random_phase(0, 150);
    random_phase(1, 150);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
